chacha20_stream_bus: RTL
========================

// Module: chacha20_stream_bus
// PURPOSE
//  Parametrised bus front-end for the ChaCha20 block core: successor to the single-block chacha20_poly1305_bus.
//  Accepts key/nonce/counter and a stream of plaintext blocks over a narrow or wide register bus.
//  Queues blocks in an input FIFO, sequences the core automatically with counter auto-increment, and queues results in an output FIFO.
// PARAMETERS
//  BUS_W       512  bus data width; one of 32,64,128,256,512; BPB = 512/BUS_W beats per block
//  ADDR_W      8    bus address width
//  FIFO_DEPTH  4    blocks per input and per output FIFO; power of two, >=2
// PORTS
//  clk             in   1       clock; all logic on rising edge
//  reset_n         in   1       asynchronous, active-low reset
//  cs              in   1       bus select
//  we              in   1       1=write, 0=read (sampled when cs=1)
//  address         in   ADDR_W  register address
//  write_data      in   BUS_W   write beat
//  read_data       out  BUS_W   registered read beat
//  core_init       out  1       1-cycle pulse: load key/nonce/ctr into core
//  core_next       out  1       1-cycle pulse: process core_block_in
//  core_key        out  256     key register
//  core_nonce      out  96      nonce register
//  core_ctr        out  32      current block counter
//  core_block_in   out  512     head of input FIFO
//  core_ready      in   1       core idle/ready
//  core_valid      in   1       1-cycle strobe: core_block_out valid
//  core_block_out  in   512     processed block
//  irq             out  1       level: (out FIFO non-empty & IRQ_EN) | error flag
// BEHAVIOUR
//  Reset: all registers, FIFOs, counters, read_data, core_init, core_next, irq = 0; FSM=IDLE.
//  Address map: 0x08 CTRL (W: b0 init, b1 run, b2 stop, b3 flush, b4 IRQ_EN; self-clearing except b4);
//   0x09 STATUS (R: b0 ready, b1 busy, b2 in_full, b3 out_nonempty, b4 ctr_wrap, b5 overflow, b6 underflow; W1C b4-b6);
//   0x0A COUNT (R: [7:0] in_count, [15:8] out_count); 0x0C CTR init value (R/W);
//   0x10+i KEY word i, 0x20+i NONCE word i (word i = bits [i*BUS_W +: BUS_W], excess bits dropped);
//   0x30 DATA push beat; 0x40 RESULT pop beat. Unmapped: write ignored, read returns 0.
//  Read latency: read_data updated on the edge after cs&!we is sampled; holds until next read.
//  Beats little-endian: beat k fills block bits [k*BUS_W +: BUS_W]; BPB-th beat commits block to input FIFO.
//  Result pop: each read of 0x40 returns next beat; after BPB-th beat, output FIFO pops.
//  Overflow: DATA beat when in_full and assembler empty -> beat dropped, overflow=1. Underflow: RESULT read when empty -> 0, underflow=1.
//  KEY/NONCE/CTR writes while busy are ignored.
//  FSM: IDLE -init-> INIT (core_init pulse, ctr<=CTR reg) -> wait core_ready -> READY.
//   READY -run-> RUN. RUN: if in_count>0 & out_count<FIFO_DEPTH & core_ready -> pulse core_next, pop input, WAIT.
//   WAIT: on core_valid push output, ctr<=ctr+1 -> RUN, or READY if stop was latched.
//   stop in RUN -> READY next cycle; stop in WAIT latched, applied after current block.
//   ctr = 0xFFFFFFFF completing -> ctr wraps to 0, ctr_wrap=1, FSM->READY; run ignored until ctr_wrap cleared.
//  busy = FSM in {INIT,RUN,WAIT}. flush clears both FIFOs and beat assemblers; ignored while in WAIT.
//  Simultaneous push to input and core pop same cycle: both take effect, count unchanged.
//  init while busy ignored. Async reset mid-block discards all state; core outputs deasserted.
// STRUCTURE
//  Package chacha20_bus_pkg: address constants, CTRL/STATUS bit indices, FSM state enum, BLOCK_W=512.
//  Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice (input, output).
// TESTING
//  BUS_W=512: key {16{00112233}}, nonce, CTR=1, init, 1 DATA beat, run -> one core_next, ctr=1, RESULT read = core model block, ctr=2.
//  BUS_W=32: 16 DATA beats -> in_count 0->1 only after 16th beat; 16 RESULT reads reassemble block in order.
//  Push FIFO_DEPTH+1 blocks with core stalled (core_ready=0) -> in_full=1, last block dropped, overflow=1, W1C clears it.
//  RESULT read on empty output -> read_data=0, underflow=1; irq=1 until cleared.
//  CTR=0xFFFFFFFF, two blocks queued -> one processed, ctr=0, ctr_wrap=1, FSM READY, in_count=1.
//  reset_n low during WAIT -> all outputs 0 immediately; after release STATUS=0, COUNT=0.

Source files
------------

// File: rtl/chacha20_bus_pkg.sv
// Shared constants for the ChaCha20 streaming bus front-end: register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package chacha20_bus_pkg;

   localparam int BLOCK_W = 512;

   localparam logic [7:0] A_CTRL   = 8'h08;
   localparam logic [7:0] A_STATUS = 8'h09;
   localparam logic [7:0] A_COUNT  = 8'h0A;
   localparam logic [7:0] A_CTR    = 8'h0C;
   localparam logic [7:0] A_KEY    = 8'h10;
   localparam logic [7:0] A_NONCE  = 8'h20;
   localparam logic [7:0] A_DATA   = 8'h30;
   localparam logic [7:0] A_RESULT = 8'h40;

   localparam int C_INIT  = 0;
   localparam int C_RUN   = 1;
   localparam int C_STOP  = 2;
   localparam int C_FLUSH = 3;
   localparam int C_IRQEN = 4;

   localparam int S_READY = 0;
   localparam int S_BUSY  = 1;
   localparam int S_INFUL = 2;
   localparam int S_OUTNE = 3;
   localparam int S_WRAP  = 4;
   localparam int S_OVF   = 5;
   localparam int S_UDF   = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_READY,
      ST_RUN,
      ST_WAIT
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous block FIFO with clear; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_clr,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_din,
   output logic [WIDTH-1:0]       o_dout,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_dout    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge clk)
      if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_din;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/chacha20_stream_bus.sv
// Register-bus front-end that streams plaintext blocks through a ChaCha20 core,
// with input/output block FIFOs and automatic counter advance per block.
module chacha20_stream_bus
   import chacha20_bus_pkg::*;
#(
   parameter int BUS_W      = 512,
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cs,
   input  logic               we,
   input  logic [ADDR_W-1:0]  address,
   input  logic [BUS_W-1:0]   write_data,
   output logic [BUS_W-1:0]   read_data,
   output logic               core_init,
   output logic               core_next,
   output logic [255:0]       core_key,
   output logic [95:0]        core_nonce,
   output logic [31:0]        core_ctr,
   output logic [BLOCK_W-1:0] core_block_in,
   input  logic               core_ready,
   input  logic               core_valid,
   input  logic [BLOCK_W-1:0] core_block_out,
   output logic               irq
);
   localparam int BPB    = BLOCK_W / BUS_W;
   localparam int KW     = (256 + BUS_W - 1) / BUS_W;
   localparam int NW     = (96 + BUS_W - 1) / BUS_W;
   localparam int CW     = $clog2(FIFO_DEPTH) + 1;
   localparam int BEAT_W = 5;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPB - 1);

   state_t               r_state;
   logic                 r_core_init, r_core_next, r_stop_lat, r_wrap;
   logic [31:0]          r_ctr, r_ctr_init;
   logic                 r_irq_en, r_ovf, r_udf;
   logic [BUS_W-1:0]     r_rdata;
   logic [BLOCK_W-1:0]   r_in_asm;
   logic [BEAT_W-1:0]    r_in_beat, r_out_beat;

   logic                 w_wr, w_rd, w_busy, w_cfg_wr, w_ctrl_wr, w_status_wr;
   logic                 w_init, w_run, w_stop, w_flush;
   logic                 w_data_wr, w_res_rd, w_in_drop, w_udf;
   logic                 w_in_push, w_in_pop, w_out_push, w_out_pop;
   logic                 w_in_full, w_in_empty, w_out_full, w_out_empty;
   logic [CW-1:0]        w_in_count, w_out_count;
   logic [BLOCK_W-1:0]   w_in_head, w_out_head, w_in_blk;
   logic [BUS_W-1:0]     w_res_beat, w_rdata;
   logic [6:0]           w_status;

   assign w_wr        = cs & we;
   assign w_rd        = cs & ~we;
   assign w_busy      = (r_state == ST_INIT) | (r_state == ST_RUN) | (r_state == ST_WAIT);
   assign w_cfg_wr    = w_wr & ~w_busy;
   assign w_ctrl_wr   = w_wr && (address == ADDR_W'(A_CTRL));
   assign w_status_wr = w_wr && (address == ADDR_W'(A_STATUS));
   assign w_init      = w_ctrl_wr & write_data[C_INIT];
   assign w_run       = w_ctrl_wr & write_data[C_RUN];
   assign w_stop      = w_ctrl_wr & write_data[C_STOP];
   assign w_flush     = w_ctrl_wr & write_data[C_FLUSH] & (r_state != ST_WAIT);
   assign w_data_wr   = w_wr && (address == ADDR_W'(A_DATA));
   assign w_res_rd    = w_rd && (address == ADDR_W'(A_RESULT));

   // A beat is lost if it would start or finish a block with no room left.
   assign w_in_drop  = w_data_wr & w_in_full & ~w_in_pop &
                       ((r_in_beat == '0) | (r_in_beat == LAST_BEAT));
   assign w_in_push  = w_data_wr & (r_in_beat == LAST_BEAT) & ~w_in_drop;
   // Pop one cycle late so the core sees the block while core_next is high.
   assign w_in_pop   = r_core_next;
   assign w_out_push = (r_state == ST_WAIT) & core_valid;
   assign w_out_pop  = w_res_rd & ~w_out_empty & (r_out_beat == LAST_BEAT);
   assign w_udf      = w_res_rd & w_out_empty;

   always_comb begin
      w_in_blk = r_in_asm;
      for (int k = 0; k < BPB; k++)
         if (r_in_beat == BEAT_W'(k)) w_in_blk[k*BUS_W +: BUS_W] = write_data;
   end

   sync_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clk(clk), .reset_n(reset_n), .i_clr(w_flush), .i_push(w_in_push), .i_pop(w_in_pop),
      .i_din(w_in_blk), .o_dout(w_in_head), .o_full(w_in_full), .o_empty(w_in_empty),
      .o_count(w_in_count)
   );

   sync_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk(clk), .reset_n(reset_n), .i_clr(w_flush), .i_push(w_out_push), .i_pop(w_out_pop),
      .i_din(core_block_out), .o_dout(w_out_head), .o_full(w_out_full), .o_empty(w_out_empty),
      .o_count(w_out_count)
   );

   for (genvar gi = 0; gi < KW; gi++) begin : g_key
      localparam int LO = gi * BUS_W;
      localparam int WD = (256 - LO < BUS_W) ? (256 - LO) : BUS_W;
      logic [WD-1:0] r_word;
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) r_word <= '0;
         else if (w_cfg_wr && address == ADDR_W'(A_KEY + gi)) r_word <= write_data[WD-1:0];
      assign core_key[LO +: WD] = r_word;
   end

   for (genvar gi = 0; gi < NW; gi++) begin : g_nonce
      localparam int LO = gi * BUS_W;
      localparam int WD = (96 - LO < BUS_W) ? (96 - LO) : BUS_W;
      logic [WD-1:0] r_word;
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) r_word <= '0;
         else if (w_cfg_wr && address == ADDR_W'(A_NONCE + gi)) r_word <= write_data[WD-1:0];
      assign core_nonce[LO +: WD] = r_word;
   end

   always_comb begin
      w_status          = '0;
      w_status[S_READY] = (r_state == ST_READY);
      w_status[S_BUSY]  = w_busy;
      w_status[S_INFUL] = w_in_full;
      w_status[S_OUTNE] = ~w_out_empty;
      w_status[S_WRAP]  = r_wrap;
      w_status[S_OVF]   = r_ovf;
      w_status[S_UDF]   = r_udf;
   end

   always_comb begin
      w_res_beat = '0;
      for (int k = 0; k < BPB; k++)
         if (r_out_beat == BEAT_W'(k)) w_res_beat = w_out_head[k*BUS_W +: BUS_W];
      w_rdata = '0;
      if (address == ADDR_W'(A_STATUS))      w_rdata = BUS_W'(w_status);
      else if (address == ADDR_W'(A_COUNT))  w_rdata = BUS_W'({8'(w_out_count), 8'(w_in_count)});
      else if (address == ADDR_W'(A_CTR))    w_rdata = BUS_W'(r_ctr_init);
      else if (address == ADDR_W'(A_RESULT)) w_rdata = w_out_empty ? '0 : w_res_beat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctr_init <= '0;
         r_irq_en   <= 1'b0;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
         r_rdata    <= '0;
         r_in_asm   <= '0;
         r_in_beat  <= '0;
         r_out_beat <= '0;
      end else begin
         if (w_cfg_wr && address == ADDR_W'(A_CTR)) r_ctr_init <= write_data[31:0];
         if (w_ctrl_wr) r_irq_en <= write_data[C_IRQEN];
         if (w_status_wr && write_data[S_OVF]) r_ovf <= 1'b0;
         if (w_status_wr && write_data[S_UDF]) r_udf <= 1'b0;
         if (w_in_drop) r_ovf <= 1'b1;
         if (w_udf)     r_udf <= 1'b1;
         if (w_rd)      r_rdata <= w_rdata;
         if (w_flush) begin
            r_in_beat  <= '0;
            r_out_beat <= '0;
         end else begin
            if (w_data_wr && !(w_in_drop && r_in_beat == '0)) begin
               r_in_asm  <= w_in_blk;
               r_in_beat <= (r_in_beat == LAST_BEAT) ? '0 : r_in_beat + 1'b1;
            end
            if (w_res_rd && !w_out_empty)
               r_out_beat <= (r_out_beat == LAST_BEAT) ? '0 : r_out_beat + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_core_init <= 1'b0;
         r_core_next <= 1'b0;
         r_ctr       <= '0;
         r_stop_lat  <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_core_init <= 1'b0;
         r_core_next <= 1'b0;
         if (w_status_wr && write_data[S_WRAP]) r_wrap <= 1'b0;
         case (r_state)
            ST_IDLE:
               if (w_init) begin
                  r_core_init <= 1'b1;
                  r_ctr       <= r_ctr_init;
                  r_state     <= ST_INIT;
               end
            ST_INIT:
               if (!r_core_init && core_ready) r_state <= ST_READY;
            ST_READY:
               if (w_init) begin
                  r_core_init <= 1'b1;
                  r_ctr       <= r_ctr_init;
                  r_state     <= ST_INIT;
               end else if (w_run && !r_wrap) begin
                  r_state <= ST_RUN;
               end
            ST_RUN:
               if (w_stop) begin
                  r_state <= ST_READY;
               end else if (w_in_count != '0 && w_out_count < CW'(FIFO_DEPTH) &&
                            core_ready && !w_flush) begin
                  r_core_next <= 1'b1;
                  r_state     <= ST_WAIT;
               end
            ST_WAIT: begin
               if (w_stop) r_stop_lat <= 1'b1;
               if (core_valid) begin
                  r_stop_lat <= 1'b0;
                  if (r_ctr == 32'hFFFF_FFFF) begin
                     r_ctr   <= '0;
                     r_wrap  <= 1'b1;
                     r_state <= ST_READY;
                  end else begin
                     r_ctr   <= r_ctr + 1'b1;
                     r_state <= (r_stop_lat || w_stop) ? ST_READY : ST_RUN;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign read_data     = r_rdata;
   assign core_init     = r_core_init;
   assign core_next     = r_core_next;
   assign core_ctr      = r_ctr;
   assign core_block_in = w_in_empty ? '0 : w_in_head;
   assign irq           = (~w_out_empty & r_irq_en) | r_ovf | r_udf;

endmodule
